// File: rtl/fir_mc_engine.sv
// fir_mc_engine: multi-channel FIR with AXI-Lite tap programming, AXI-Stream I/O and one shared MAC
module fir_mc_engine #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int NUM_TAPS    = 11,
  parameter int NUM_CH      = 1
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast
);
  localparam int AW = 2*pDATA_WIDTH+5;
  localparam int PW = 2*pDATA_WIDTH;
  localparam int KW = $clog2(NUM_TAPS);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  typedef enum logic [2:0] {IDLE, CLR, WAIT_IN, MAC, OUT, DONE} state_t;
  state_t state_q, state_d;
  logic signed [pDATA_WIDTH-1:0] tap_q [NUM_TAPS];
  logic signed [pDATA_WIDTH-1:0] hist_q [NUM_CH][NUM_TAPS];
  logic signed [AW-1:0] acc_q, shifted;
  logic signed [PW-1:0] prod;
  logic [KW-1:0] k_q;
  logic [CW-1:0] ch_q;
  logic [pDATA_WIDTH-1:0] count_q, len_q, rdata_q, rd_val, sat_val;
  logic [5:0] shift_q;
  logic done_q, tlast_err_q, w_ack_q, ar_ack_q, rvalid_q;
  logic wr_en, rd_en, idle, ap_idle, start, cfg_wr, last_in, fits;
  logic [pADDR_WIDTH-1:0] widx, ridx;
  logic [AW-pDATA_WIDTH:0] top;
  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return a >= pADDR_WIDTH'(32) && a < pADDR_WIDTH'(32+4*NUM_TAPS) && a[1:0] == 2'b00;
  endfunction
  assign awready = w_ack_q;
  assign wready  = w_ack_q;
  assign arready = ar_ack_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign wr_en   = w_ack_q & awvalid & wvalid;
  assign rd_en   = ar_ack_q & arvalid;
  assign idle    = state_q == IDLE;
  assign ap_idle = idle | (state_q == DONE);
  assign start   = wr_en & (awaddr == '0) & wdata[0] & idle;
  assign cfg_wr  = wr_en & idle;
  assign widx    = (awaddr - pADDR_WIDTH'(32)) >> 2;
  assign ridx    = (araddr - pADDR_WIDTH'(32)) >> 2;
  assign last_in = count_q == len_q - pDATA_WIDTH'(1);
  assign prod    = $signed(tap_q[k_q]) * $signed(hist_q[ch_q][k_q]);
  // Saturate when the bits above the output sign bit are not a pure sign extension
  assign shifted = acc_q >>> shift_q;
  assign top     = shifted[AW-1:pDATA_WIDTH-1];
  assign fits    = (&top) | ~(|top);
  assign sat_val = fits ? shifted[pDATA_WIDTH-1:0]
                 : shifted[AW-1] ? {1'b1, {(pDATA_WIDTH-1){1'b0}}} : {1'b0, {(pDATA_WIDTH-1){1'b1}}};
  assign sm_tdata = sm_tvalid ? sat_val : '0;
  assign sm_tlast = sm_tvalid & last_in;
  always_comb begin
    rd_val = '0;
    if (araddr == '0) rd_val[3:0] = {tlast_err_q, ap_idle, done_q, 1'b0};
    else if (araddr == pADDR_WIDTH'(16)) rd_val = len_q;
    else if (araddr == pADDR_WIDTH'(20)) rd_val[5:0] = shift_q;
    for (int i = 0; i < NUM_TAPS; i++)
      if (is_tap(araddr) && ridx == pADDR_WIDTH'(i)) rd_val = ap_idle ? tap_q[i] : '1;
  end
  always_ff @(posedge axis_clk or posedge axis_rst)
    if (axis_rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d   = state_q;
    ss_tready = 1'b0;
    sm_tvalid = 1'b0;
    case (state_q)
      IDLE:    state_d = start ? CLR : IDLE;
      CLR:     state_d = len_q == '0 ? DONE : WAIT_IN;
      WAIT_IN: begin
        ss_tready = 1'b1;
        state_d   = ss_tvalid ? MAC : WAIT_IN;
      end
      MAC:     state_d = k_q == KW'(NUM_TAPS-1) ? OUT : MAC;
      OUT:     begin
        sm_tvalid = 1'b1;
        state_d   = !sm_tready ? OUT : last_in ? DONE : WAIT_IN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      for (int i = 0; i < NUM_TAPS; i++) tap_q[i] <= '0;
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < NUM_TAPS; k++) hist_q[c][k] <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      ch_q        <= '0;
      count_q     <= '0;
      len_q       <= '0;
      shift_q     <= '0;
      done_q      <= 1'b0;
      tlast_err_q <= 1'b0;
      w_ack_q     <= 1'b0;
      ar_ack_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      w_ack_q  <= awvalid & wvalid & ~w_ack_q;
      ar_ack_q <= arvalid & ~ar_ack_q & ~rvalid_q;
      if (rd_en) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
      end else if (rvalid_q & rready) rvalid_q <= 1'b0;
      if (state_d == DONE) done_q <= 1'b1;
      else if (rd_en && araddr == '0) done_q <= 1'b0;
      if (start) tlast_err_q <= 1'b0;
      else if (ss_tready && ss_tvalid && ss_tlast != last_in) tlast_err_q <= 1'b1;
      if (cfg_wr && awaddr == pADDR_WIDTH'(16)) len_q <= wdata;
      if (cfg_wr && awaddr == pADDR_WIDTH'(20)) shift_q <= wdata[5:0];
      for (int i = 0; i < NUM_TAPS; i++)
        if (cfg_wr && is_tap(awaddr) && widx == pADDR_WIDTH'(i)) tap_q[i] <= wdata;
      for (int c = 0; c < NUM_CH; c++)
        if (state_q == CLR) begin
          for (int k = 0; k < NUM_TAPS; k++) hist_q[c][k] <= '0;
        end else if (ss_tready && ss_tvalid && ch_q == CW'(c)) begin
          hist_q[c][0] <= ss_tdata;
          for (int k = 1; k < NUM_TAPS; k++) hist_q[c][k] <= hist_q[c][k-1];
        end
      if (state_q == CLR) begin
        ch_q    <= '0;
        count_q <= '0;
      end
      if (ss_tready && ss_tvalid) begin
        k_q   <= '0;
        acc_q <= '0;
      end
      if (state_q == MAC) begin
        acc_q <= acc_q + {{(AW-PW){prod[PW-1]}}, prod};
        k_q   <= k_q + 1'b1;
      end
      if (sm_tvalid && sm_tready) begin
        count_q <= count_q + pDATA_WIDTH'(1);
        ch_q    <= ch_q == CW'(NUM_CH-1) ? '0 : ch_q + 1'b1;
      end
    end
  end
endmodule
